// File: rtl/oneliner_pkg.sv
// ============================================================================
// oneliner_pkg : shared types and next-value prediction for the odd-decrement
//                byte producer and its reader.
// Rev 1.0
// ============================================================================
`default_nettype none

package oneliner_pkg;

  typedef enum logic [1:0] {
    SEED  = 2'd0,
    TRACK = 2'd1,
    FAIL  = 2'd2
  } reader_state_e;

  localparam int C_STEP_DEF = 7;
  localparam int C_PRED_W   = 32;

  // Callers truncate the result to their own data width; the low bits of the
  // wide subtraction equal the modulo-2^W result, borrow discarded.
  function automatic logic [C_PRED_W-1:0] predict(
    input logic [C_PRED_W-1:0] value,
    input logic [C_PRED_W-1:0] step
  );
    return value[0] ? (value - step) : value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/oneliner_reader_sat_counter.sv
// ============================================================================
// sat_counter : up-counter that sticks at all-ones, with synchronous clear.
// Rev 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/oneliner_reader.sv
// ============================================================================
// oneliner_reader : samples the producer stream, predicts each next value and
//                   counts samples / mismatches, latching a sticky fail.
// Rev 1.0
// ============================================================================
`default_nettype none

module oneliner_reader
  import oneliner_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int STEP    = C_STEP_DEF,
  parameter int CNT_W   = 16,
  parameter int MAX_ERR = 1
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              clear,
  output logic              settled,
  output logic              fail,
  output logic [DATA_W-1:0] last_val,
  output logic [CNT_W-1:0]  n_samples,
  output logic [CNT_W-1:0]  n_errors
);

  reader_state_e     r_state;
  reader_state_e     w_state_next;
  logic [1:0]        r_sync;
  logic [DATA_W-1:0] r_last_val;
  logic              r_settled;
  logic [DATA_W-1:0] w_exp;
  logic              w_xfer;
  logic              w_mismatch;
  logic              w_err_reach;
  logic              w_accept_state;

  // Release of rst_n is retimed so in_ready only rises on the 2nd clock edge.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], 1'b1};
    end
  end

  always_comb begin
    w_exp = DATA_W'(predict(C_PRED_W'(r_last_val), C_PRED_W'(STEP)));
  end

  assign w_xfer      = in_valid & in_ready;
  assign w_mismatch  = w_xfer && (r_state == TRACK) && (in_data != w_exp);
  assign w_err_reach = ((CNT_W+1)'(n_errors) + (CNT_W+1)'(1)) >= (CNT_W+1)'(MAX_ERR);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = SEED;
    end else begin
      case (r_state)
        SEED:    if (w_xfer) w_state_next = TRACK;
        TRACK:   if (w_mismatch && w_err_reach) w_state_next = FAIL;
        FAIL:    w_state_next = FAIL;
        default: w_state_next = SEED;
      endcase
    end
  end

  always_comb begin
    w_accept_state = (r_state != FAIL);
    fail           = (r_state == FAIL);
  end

  assign in_ready = r_sync[1] & w_accept_state;

  // On a mismatch the observed value is adopted, so one glitch costs one error.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_last_val <= '0;
      r_settled  <= 1'b0;
    end else if (clear) begin
      r_last_val <= '0;
      r_settled  <= 1'b0;
    end else if (w_xfer) begin
      r_last_val <= in_data;
      r_settled  <= ~in_data[0];
    end
  end

  assign last_val = r_last_val;
  assign settled  = r_settled;

  sat_counter #(.CNT_W(CNT_W)) u_samples (
    .clock (clock),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (w_xfer & ~clear),
    .count (n_samples)
  );

  sat_counter #(.CNT_W(CNT_W)) u_errors (
    .clock (clock),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (w_mismatch & ~clear),
    .count (n_errors)
  );

endmodule

`default_nettype wire

// File: tb/tb_oneliner_reader.sv
// ============================================================================
// tb_oneliner_reader : directed checks of oneliner_reader (CNT_W=16 and 2).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_oneliner_reader;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        in_valid, clear;
  logic [7:0]  in_data;
  logic        in_ready, settled, fail;
  logic [7:0]  last_val;
  logic [15:0] n_samples, n_errors;

  logic        valid2, clear2;
  logic [7:0]  data2;
  logic        ready2, settled2, fail2;
  logic [7:0]  last2;
  logic [1:0]  samples2, errors2;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  oneliner_reader #(.DATA_W(8), .STEP(7), .CNT_W(16), .MAX_ERR(1)) dut (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .clear(clear), .settled(settled), .fail(fail),
    .last_val(last_val), .n_samples(n_samples), .n_errors(n_errors)
  );

  oneliner_reader #(.DATA_W(8), .STEP(7), .CNT_W(2), .MAX_ERR(1)) dut2 (
    .clock(clock), .rst_n(rst_n), .in_valid(valid2), .in_data(data2),
    .in_ready(ready2), .clear(clear2), .settled(settled2), .fail(fail2),
    .last_val(last2), .n_samples(samples2), .n_errors(errors2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; clear = 1'b0;
    valid2 = 1'b0; data2 = 8'h00; clear2 = 1'b0;
    repeat (3) tick();
    check("rst_ready",   32'(in_ready),  32'h0);
    check("rst_settled", 32'(settled),   32'h0);
    check("rst_fail",    32'(fail),      32'h0);
    check("rst_last",    32'(last_val),  32'h0);
    check("rst_samples", 32'(n_samples), 32'h0);
    check("rst_errors",  32'(n_errors),  32'h0);

    rst_n = 1'b1;
    tick();
    check("rel_ready_1st", 32'(in_ready), 32'h0);
    tick();
    check("rel_ready_2nd", 32'(in_ready), 32'h1);

    // 0F -> 08 -> 08
    in_valid = 1'b1; in_data = 8'h0F; tick();
    check("s1_seed_settled", 32'(settled), 32'h0);
    in_data = 8'h08; tick();
    in_data = 8'h08; tick();
    in_valid = 1'b0;
    check("s1_samples", 32'(n_samples), 32'd3);
    check("s1_errors",  32'(n_errors),  32'd0);
    check("s1_settled", 32'(settled),   32'h1);
    check("s1_last",    32'(last_val),  32'h08);
    check("s1_fail",    32'(fail),      32'h0);

    // 03 -> FC wraps
    clear = 1'b1; tick(); clear = 1'b0;
    in_valid = 1'b1; in_data = 8'h03; tick();
    in_data = 8'hFC; tick();
    check("s2_wrap_errors", 32'(n_errors), 32'd0);
    check("s2_wrap_last",   32'(last_val), 32'hFC);
    in_data = 8'hFC; tick();
    in_valid = 1'b0;
    check("s2_settled", 32'(settled),   32'h1);
    check("s2_errors",  32'(n_errors),  32'd0);
    check("s2_samples", 32'(n_samples), 32'd3);

    // 11 -> 0B (0A expected) fails
    clear = 1'b1; tick(); clear = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; tick();
    in_data = 8'h0B; tick();
    check("s3_errors", 32'(n_errors), 32'd1);
    check("s3_fail",   32'(fail),     32'h1);
    check("s3_ready",  32'(in_ready), 32'h0);
    check("s3_last",   32'(last_val), 32'h0B);
    in_data = 8'h0A; tick();
    check("s3_no_accept", 32'(n_samples), 32'd2);
    check("s3_fail_held", 32'(fail),      32'h1);

    // clear beats a same-cycle transfer
    in_data = 8'h55; clear = 1'b1; tick(); clear = 1'b0; in_valid = 1'b0;
    check("s4_samples", 32'(n_samples), 32'd0);
    check("s4_errors",  32'(n_errors),  32'd0);
    check("s4_last",    32'(last_val),  32'h00);
    check("s4_fail",    32'(fail),      32'h0);
    check("s4_ready",   32'(in_ready),  32'h1);
    in_valid = 1'b1; in_data = 8'h20; tick(); in_valid = 1'b0;
    check("s4_reseed_errors",  32'(n_errors),  32'd0);
    check("s4_reseed_samples", 32'(n_samples), 32'd1);

    // async reset between 21 and 1A
    clear = 1'b1; tick(); clear = 1'b0;
    in_valid = 1'b1; in_data = 8'h21; tick(); in_valid = 1'b0;
    check("s5_pre_last", 32'(last_val), 32'h21);
    #2 rst_n = 1'b0;
    #1;
    check("s5_async_last",    32'(last_val),  32'h00);
    check("s5_async_samples", 32'(n_samples), 32'd0);
    check("s5_async_ready",   32'(in_ready),  32'h0);
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 8'h1A;
    tick();
    check("s5_rel1_ready",   32'(in_ready),  32'h0);
    check("s5_rel1_samples", 32'(n_samples), 32'd0);
    tick();
    check("s5_rel2_ready",   32'(in_ready),  32'h1);
    check("s5_rel2_samples", 32'(n_samples), 32'd0);
    tick();
    check("s5_seed_samples", 32'(n_samples), 32'd1);
    check("s5_seed_last",    32'(last_val),  32'h1A);
    check("s5_seed_settled", 32'(settled),   32'h1);
    tick();
    in_valid = 1'b0;
    check("s5_hold_errors",  32'(n_errors),  32'd0);
    check("s5_hold_samples", 32'(n_samples), 32'd2);

    // 2-bit counters saturate
    valid2 = 1'b1; data2 = 8'h04;
    repeat (4) tick();
    check("s6_sat_4", 32'(samples2), 32'd3);
    tick();
    valid2 = 1'b0;
    check("s6_sat_5",    32'(samples2), 32'd3);
    check("s6_errors",   32'(errors2),  32'd0);
    check("s6_fail",     32'(fail2),    32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
